// File: rtl/ant_base_pkt_framer_if.sv
// Framer data-path bundle: the payload stream into the framer and the framed stream out.
interface ant_base_pkt_framer_if;
    logic [63:0] din;
    logic        din_valid;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_sof;
    logic        dout_eof;

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, dout_sof, dout_eof
    );

    modport master (
        output din, din_valid,
        input  dout, dout_valid, dout_sof, dout_eof
    );
endinterface

// File: rtl/ant_base_pkt_framer.sv
// Cuts the channelized 64-bit stream into PKT_WORDS-word packets, each prefixed by a
// header {mcnt, ant_base + ant_idx, PKT_WORDS}, for the 10GbE transmit path.
module ant_base_pkt_framer #(
    parameter int PKT_WORDS = 128,
    parameter int N_ANT     = 4
) (
    input  logic                         user_clk,
    input  logic                         user_rst_n,
    input  logic [31:0]                  ant_base,
    input  logic                         sync_in,
    input  logic                         err_clr,
    ant_base_pkt_framer_if.slave         bus,
    output logic                         err_overrun,
    output logic                         err_sync
);
    localparam int              AW       = (N_ANT > 1) ? $clog2(N_ANT) : 1;
    localparam logic [15:0]     PKT_LEN  = 16'(PKT_WORDS);
    localparam logic [AW-1:0]   ANT_LAST = AW'(N_ANT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t         state, state_nxt;
    logic [15:0]    wcnt, wcnt_nxt, wcnt_inc;
    logic [31:0]    mcnt, mcnt_nxt;
    logic [AW-1:0]  ant_idx, idx_nxt;
    logic [15:0]    base_q, base_cur;
    logic           base_load;
    logic           last_q, last_nxt;
    logic           hdr_fire, pay_acc, pay_last, adv;
    logic           set_ovr, set_sync;
    logic [63:0]    hdr;

    logic [63:0]    d_p0;
    logic           vld_p0, eof_p0;

    logic           unused_hi;
    assign unused_hi = ^ant_base[31:16];

    function automatic logic [63:0] pack_hdr(input logic [31:0] m, input logic [15:0] base,
                                             input logic [AW-1:0] idx);
        return {m, base + 16'(idx), PKT_LEN};
    endfunction

    // Header fields seen at the first-word cycle; a coincident sync restarts numbering.
    assign base_cur = (sync_in || base_load) ? ant_base[15:0] : base_q;
    assign hdr      = sync_in ? pack_hdr(32'd0, base_cur, '0)
                              : pack_hdr(mcnt, base_cur, ant_idx);
    assign wcnt_inc = wcnt + 16'd1;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        hdr_fire  = 1'b0;
        pay_acc   = 1'b0;
        pay_last  = 1'b0;
        adv       = 1'b0;
        set_ovr   = 1'b0;
        set_sync  = 1'b0;
        last_nxt  = 1'b0;
        if (sync_in) begin
            set_sync = (state != IDLE) && (wcnt != 16'd0);
            if (bus.din_valid) begin
                hdr_fire  = 1'b1;
                pay_acc   = 1'b1;
                wcnt_nxt  = 16'd1;
                state_nxt = RUN;
            end else begin
                wcnt_nxt  = 16'd0;
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: if (bus.din_valid) begin
                    wcnt_nxt = 16'd1;
                    if (last_q) begin
                        set_ovr   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        hdr_fire  = 1'b1;
                        pay_acc   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN, DROP: if (bus.din_valid) begin
                    pay_acc = (state == RUN);
                    if (wcnt_inc == PKT_LEN) begin
                        pay_last  = (state == RUN);
                        adv       = 1'b1;
                        last_nxt  = 1'b1;
                        wcnt_nxt  = 16'd0;
                        state_nxt = IDLE;
                    end else begin
                        wcnt_nxt = wcnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Dropped packets still advance numbering so it stays aligned to the spectrum.
        mcnt_nxt = mcnt;
        idx_nxt  = ant_idx;
        if (sync_in) begin
            mcnt_nxt = 32'd0;
            idx_nxt  = '0;
        end else if (adv) begin
            if (ant_idx == ANT_LAST) begin
                idx_nxt  = '0;
                mcnt_nxt = mcnt + 32'd1;
            end else begin
                idx_nxt  = ant_idx + AW'(1);
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state       <= IDLE;
            wcnt        <= 16'd0;
            mcnt        <= 32'd0;
            ant_idx     <= '0;
            base_q      <= 16'd0;
            base_load   <= 1'b1;
            last_q      <= 1'b0;
            err_overrun <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            mcnt        <= mcnt_nxt;
            ant_idx     <= idx_nxt;
            last_q      <= last_nxt;
            base_load   <= 1'b0;
            if (sync_in || base_load)
                base_q <= ant_base[15:0];
            err_overrun <= set_ovr  | (err_overrun & ~err_clr);
            err_sync    <= set_sync | (err_sync & ~err_clr);
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            d_p0           <= 64'd0;
            vld_p0         <= 1'b0;
            eof_p0         <= 1'b0;
            bus.dout       <= 64'd0;
            bus.dout_valid <= 1'b0;
            bus.dout_sof   <= 1'b0;
            bus.dout_eof   <= 1'b0;
        end else begin
            // p0: payload held one cycle to open the slot for the header
            d_p0   <= bus.din;
            vld_p0 <= pay_acc;
            eof_p0 <= pay_last;
            // p1: output mux; an in-flight payload word beats a header on collision
            if (vld_p0) begin
                bus.dout       <= d_p0;
                bus.dout_valid <= 1'b1;
                bus.dout_sof   <= 1'b0;
                bus.dout_eof   <= eof_p0;
            end else if (hdr_fire) begin
                bus.dout       <= hdr;
                bus.dout_valid <= 1'b1;
                bus.dout_sof   <= 1'b1;
                bus.dout_eof   <= 1'b0;
            end else begin
                bus.dout       <= 64'd0;
                bus.dout_valid <= 1'b0;
                bus.dout_sof   <= 1'b0;
                bus.dout_eof   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ant_base_pkt_framer.sv
// Directed bench for ant_base_pkt_framer (PKT_WORDS=4, N_ANT=2) with a cycle-stamped scoreboard.
module tb_ant_base_pkt_framer;
    logic        clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] ant_base;
    logic        sync_in;
    logic        err_clr;
    logic        err_overrun;
    logic        err_sync;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int          c;
        logic        sof;
        logic        eof;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    ant_base_pkt_framer_if bus ();

    ant_base_pkt_framer #(.PKT_WORDS(4), .N_ANT(2)) dut (
        .user_clk    (clk),
        .user_rst_n  (user_rst_n),
        .ant_base    (ant_base),
        .sync_in     (sync_in),
        .err_clr     (err_clr),
        .bus         (bus.slave),
        .err_overrun (err_overrun),
        .err_sync    (err_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input int c, input logic s, input logic e, input logic [63:0] d);
        exp_t x;
        x.c = c; x.sof = s; x.eof = e; x.data = d;
        exp_q.push_back(x);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Full 4-word packet; bub[i] inserts a bubble after word i, gap adds one idle cycle.
    task automatic pkt(input logic [63:0] hdr, input logic [63:0] d0, input bit sync,
                       input bit emit, input bit [2:0] bub, input bit gap);
        for (int i = 0; i < 4; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = d0 + 64'(i);
            sync_in       = sync && (i == 0);
            if (emit) begin
                if (i == 0) push(cyc + 1, 1'b1, 1'b0, hdr);
                push(cyc + 2, 1'b0, (i == 3), d0 + 64'(i));
            end
            step();
            sync_in       = 1'b0;
            bus.din_valid = 1'b0;
            if (i < 3 && bub[i]) step();
        end
        if (gap) step();
    endtask

    // Leading words of a packet only; none of them may carry eof.
    task automatic part(input logic [63:0] hdr, input logic [63:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = d0 + 64'(i);
            if (i == 0) push(cyc + 1, 1'b1, 1'b0, hdr);
            push(cyc + 2, 1'b0, 1'b0, d0 + 64'(i));
            step();
            bus.din_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got %h sof=%b eof=%b at cycle %0d, required no output",
                         bus.dout, bus.dout_sof, bus.dout_eof, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.c || bus.dout_sof !== e.sof || bus.dout_eof !== e.eof || bus.dout !== e.data) begin
                    n_fail++;
                    $display("FAIL out_word: got %h sof=%b eof=%b cyc=%0d, required %h sof=%b eof=%b cyc=%0d",
                             bus.dout, bus.dout_sof, bus.dout_eof, cyc, e.data, e.sof, e.eof, e.c);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"},        bus.dout,            64'd0);
        check({tag, "_dout_valid"},  64'(bus.dout_valid), 64'd0);
        check({tag, "_dout_sof"},    64'(bus.dout_sof),   64'd0);
        check({tag, "_dout_eof"},    64'(bus.dout_eof),   64'd0);
        check({tag, "_err_overrun"}, 64'(err_overrun),    64'd0);
        check({tag, "_err_sync"},    64'(err_sync),       64'd0);
    endtask

    initial begin
        user_rst_n    = 1'b0;
        ant_base      = 32'h0000_0010;
        sync_in       = 1'b0;
        err_clr       = 1'b0;
        bus.din       = 64'd0;
        bus.din_valid = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        user_rst_n = 1'b1;
        step();

        // basic framing and rollover of ant_idx into mcnt
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        pkt(64'h0000_0000_0010_0004, 64'hA0, 1'b0, 1'b1, 3'b000, 1'b1);
        pkt(64'h0000_0000_0011_0004, 64'hB0, 1'b0, 1'b1, 3'b000, 1'b1);
        pkt(64'h0000_0001_0010_0004, 64'hC0, 1'b0, 1'b1, 3'b000, 1'b1);
        pkt(64'h0000_0001_0011_0004, 64'hD0, 1'b0, 1'b1, 3'b000, 1'b1);
        check("no_overrun_yet", 64'(err_overrun), 64'd0);

        // overrun: second packet starts right after the last word and is dropped
        pkt(64'h0000_0002_0010_0004, 64'hE0, 1'b0, 1'b1, 3'b000, 1'b0);
        pkt(64'h0,                   64'hF0, 1'b0, 1'b0, 3'b000, 1'b1);
        check("err_overrun_set", 64'(err_overrun), 64'd1);
        pkt(64'h0000_0003_0010_0004, 64'h100, 1'b0, 1'b1, 3'b000, 1'b1);
        check("err_overrun_sticky", 64'(err_overrun), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_overrun_clr", 64'(err_overrun), 64'd0);
        check("err_sync_clean", 64'(err_sync), 64'd0);

        // mcnt wrap at 2^32
        force dut.mcnt = 32'hFFFF_FFFF;
        step();
        release dut.mcnt;
        pkt(64'hFFFF_FFFF_0011_0004, 64'h110, 1'b0, 1'b1, 3'b000, 1'b1);
        pkt(64'h0000_0000_0010_0004, 64'h120, 1'b0, 1'b1, 3'b000, 1'b1);

        // mid-packet sync: partial words still flow, numbering restarts at new base
        part(64'h0000_0000_0011_0004, 64'h130, 2);
        ant_base = 32'hABCD_0020;
        sync_in  = 1'b1;
        step();
        sync_in  = 1'b0;
        check("err_sync_set", 64'(err_sync), 64'd1);
        step();
        pkt(64'h0000_0000_0020_0004, 64'h140, 1'b0, 1'b1, 3'b000, 1'b1);

        // ant_base change without sync is ignored; bubbles keep +2 latency
        ant_base = 32'h0000_5555;
        pkt(64'h0000_0000_0021_0004, 64'h150, 1'b0, 1'b1, 3'b101, 1'b1);
        check("err_sync_sticky", 64'(err_sync), 64'd1);

        // sync coincident with the first word
        ant_base = 32'h0000_0040;
        pkt(64'h0000_0000_0040_0004, 64'h160, 1'b1, 1'b1, 3'b000, 1'b1);

        // reset mid-packet: in-flight word discarded, then base reloads at release
        part(64'h0000_0000_0041_0004, 64'h170, 1);
        bus.din_valid = 1'b1;
        bus.din       = 64'h171;
        step();
        bus.din_valid = 1'b0;
        ant_base      = 32'h0000_0030;
        user_rst_n    = 1'b0;
        step();
        check_outputs_zero("rst_mid");
        user_rst_n = 1'b1;
        step();
        pkt(64'h0000_0000_0030_0004, 64'h180, 1'b0, 1'b1, 3'b000, 1'b1);

        repeat (4) step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_words: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
